// File: rtl/pipearch_common_pkg.sv
// Shared pipeline-architecture types: write engine states, access properties, fifobram selects.
// Also hosts the configreg decode so read and write engines interpret it identically.
package pipearch_common;

    localparam int LOG2_ACCESS_SIZE = 14;
    localparam int OFFSET_WIDTH     = 14;

    localparam logic [1:0] SEL_BRAM = 2'b01;
    localparam logic [1:0] SEL_FIFO = 2'b10;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_BRAM_WRITE,
        WS_FIFO_WRITE
    } t_writestate;

    typedef struct packed {
        logic [OFFSET_WIDTH-1:0]     offset;
        logic [LOG2_ACCESS_SIZE-1:0] length;
        logic [15:0]                 iterations;
        logic                        write_bram;
        logic                        write_fifo;
        logic                        keep_count_along_iterations;
    } access_properties;

    function automatic access_properties decode_config(input logic [31:0] cfg,
                                                       input logic [15:0] iters);
        access_properties p;
        p.write_fifo                  = cfg[31];
        p.write_bram                  = cfg[30];
        p.length                      = cfg[29:16];
        p.keep_count_along_iterations = cfg[15];
        p.offset                      = cfg[13:0];
        p.iterations                  = iters;
        return p;
    endfunction

endpackage

// File: rtl/write_region.sv
// Writes a pipeline result stream into a fifobram region, as sequential BRAM lines or FIFO pushes.
// Latency: one cycle from accepted beat to region write. Backpressure: registered in_almostfull, 2-beat slack.
// Beats are never dropped in a write state; beats arriving while idle are discarded and flagged.
module write_region #(
    parameter int DATA_WIDTH       = 512,
    parameter int ADDR_WIDTH       = 14,
    parameter int LOG2_ACCESS_SIZE = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    input  logic [31:0]           configreg,
    input  logic [15:0]           iterations,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_almostfull,
    input  logic                  region_almostfull,
    output logic                  region_we,
    output logic [1:0]            region_wfifobram,
    output logic [ADDR_WIDTH-1:0] region_waddr,
    output logic [DATA_WIDTH-1:0] region_wdata,
    output logic                  busy,
    output logic                  op_done,
    output logic                  overflow
);
    import pipearch_common::t_writestate;
    import pipearch_common::access_properties;
    import pipearch_common::decode_config;
    import pipearch_common::WS_IDLE;
    import pipearch_common::WS_BRAM_WRITE;
    import pipearch_common::WS_FIFO_WRITE;
    import pipearch_common::SEL_BRAM;
    import pipearch_common::SEL_FIFO;

    localparam int REM_WIDTH = LOG2_ACCESS_SIZE + 16;

    t_writestate                 state, state_n;
    access_properties            props;
    logic [ADDR_WIDTH-1:0]       offset_q, offset_n;
    logic [LOG2_ACCESS_SIZE-1:0] length_q, length_n, line_q, line_n;
    logic [15:0]                 iters_q, iters_n, iter_q, iter_n;
    logic                        keep_q, keep_n;
    logic [REM_WIDTH-1:0]        remain_q, remain_n;

    logic                  we_n, done_n, ovf_n, afull_n;
    logic [1:0]            sel_n;
    logic [ADDR_WIDTH-1:0] waddr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic                  last_line, last_iter;
    logic                  unused_cfg;

    assign props      = decode_config(configreg, iterations);
    assign unused_cfg = ^{configreg[14], props.write_bram};
    assign last_line  = (line_q == length_q - 1'b1);
    assign last_iter  = (iter_q == iters_q - 16'd1);
    assign busy       = (state != WS_IDLE);

    always_comb begin
        state_n  = state;
        offset_n = offset_q;
        length_n = length_q;
        iters_n  = iters_q;
        keep_n   = keep_q;
        line_n   = line_q;
        iter_n   = iter_q;
        remain_n = remain_q;
        we_n     = 1'b0;
        sel_n    = 2'b00;
        waddr_n  = region_waddr;
        wdata_n  = region_wdata;
        done_n   = 1'b0;
        ovf_n    = overflow;

        case (state)
            WS_IDLE: begin
                if (op_start) begin
                    offset_n = ADDR_WIDTH'(props.offset);
                    length_n = LOG2_ACCESS_SIZE'(props.length);
                    iters_n  = props.iterations;
                    keep_n   = props.keep_count_along_iterations;
                    line_n   = '0;
                    iter_n   = '0;
                    remain_n = REM_WIDTH'(length_n) * REM_WIDTH'(iters_n);
                    ovf_n    = 1'b0;
                    if (props.length == '0 || props.iterations == '0)
                        done_n = 1'b1;
                    else if (props.write_fifo)
                        state_n = WS_FIFO_WRITE;
                    else
                        state_n = WS_BRAM_WRITE;
                end
                // A beat in the op_start cycle still counts as an idle overflow.
                if (in_valid)
                    ovf_n = 1'b1;
            end
            default: begin
                if (in_valid) begin
                    we_n     = 1'b1;
                    wdata_n  = in_data;
                    remain_n = remain_q - 1'b1;
                    if (state == WS_FIFO_WRITE) begin
                        sel_n = SEL_FIFO;
                    end else begin
                        sel_n   = SEL_BRAM;
                        waddr_n = offset_q + ADDR_WIDTH'(line_q);
                    end
                    if (last_line) begin
                        line_n = '0;
                        iter_n = iter_q + 16'd1;
                        if (last_iter) begin
                            state_n = WS_IDLE;
                            done_n  = 1'b1;
                        end else if (keep_q && state == WS_BRAM_WRITE) begin
                            offset_n = offset_q + ADDR_WIDTH'(length_q);
                        end
                    end else begin
                        line_n = line_q + 1'b1;
                    end
                end
            end
        endcase

        // Evaluated on post-edge counters so the producer's 2 in-flight beats never overshoot.
        afull_n = (state_n == WS_IDLE)
               || (state_n == WS_FIFO_WRITE && region_almostfull)
               || (remain_n <= REM_WIDTH'(2));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= WS_IDLE;
            offset_q         <= '0;
            length_q         <= '0;
            iters_q          <= '0;
            keep_q           <= 1'b0;
            line_q           <= '0;
            iter_q           <= '0;
            remain_q         <= '0;
            region_we        <= 1'b0;
            region_wfifobram <= 2'b00;
            region_waddr     <= '0;
            region_wdata     <= '0;
            op_done          <= 1'b0;
            overflow         <= 1'b0;
            in_almostfull    <= 1'b1;
        end else begin
            state            <= state_n;
            offset_q         <= offset_n;
            length_q         <= length_n;
            iters_q          <= iters_n;
            keep_q           <= keep_n;
            line_q           <= line_n;
            iter_q           <= iter_n;
            remain_q         <= remain_n;
            region_we        <= we_n;
            region_wfifobram <= sel_n;
            region_waddr     <= waddr_n;
            region_wdata     <= wdata_n;
            op_done          <= done_n;
            overflow         <= ovf_n;
            in_almostfull    <= afull_n;
        end
    end

endmodule

// File: tb/tb_write_region.sv
// Directed bench for write_region: vector table for single-op flows, hand sequences for wrap, FIFO and reset.
module tb_write_region;

    localparam int DW = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_start;
    logic [31:0]   configreg;
    logic [15:0]   iterations;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_almostfull;
    logic          region_almostfull;
    logic          region_we;
    logic [1:0]    region_wfifobram;
    logic [AW-1:0] region_waddr;
    logic [DW-1:0] region_wdata;
    logic          busy;
    logic          op_done;
    logic          overflow;

    int tests  = 0;
    int failed = 0;

    write_region #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOG2_ACCESS_SIZE(14)) dut (
        .clk               (clk),
        .reset             (reset),
        .op_start          (op_start),
        .configreg         (configreg),
        .iterations        (iterations),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_almostfull     (in_almostfull),
        .region_almostfull (region_almostfull),
        .region_we         (region_we),
        .region_wfifobram  (region_wfifobram),
        .region_waddr      (region_waddr),
        .region_wdata      (region_wdata),
        .busy              (busy),
        .op_done           (op_done),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] cfg;
        logic [15:0] it;
        logic        vld;
        logic [31:0] dat;
        logic        e_we;
        logic [13:0] e_addr;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
        logic        e_afull;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] c, input logic [15:0] it,
                         input logic v, input logic [31:0] d, input logic ra);
        op_start          = st;
        configreg         = c;
        iterations        = it;
        in_valid          = v;
        in_data           = d;
        region_almostfull = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int dones;
        int writes;
        logic [13:0] exp_addr[8];

        reset = 1'b0;
        idle();
        #12;
        check("rst we",    64'(region_we), 64'd0);
        check("rst sel",   64'(region_wfifobram), 64'd0);
        check("rst waddr", 64'(region_waddr), 64'd0);
        check("rst wdata", 64'(region_wdata), 64'd0);
        check("rst busy",  64'(busy), 64'd0);
        check("rst done",  64'(op_done), 64'd0);
        check("rst ovf",   64'(overflow), 64'd0);
        check("rst afull", 64'(in_almostfull), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // st cfg it vld dat | we addr data busy done ovf afull
        vecs[0]  = '{1'b1, 32'h4004_0010, 16'd1, 1'b0, 32'h0,   1'b0, 14'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         16'd0, 1'b1, 32'hA0,  1'b1, 14'h10, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         16'd0, 1'b1, 32'hA1,  1'b1, 14'h11, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         16'd0, 1'b1, 32'hA2,  1'b1, 14'h12, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,         16'd0, 1'b1, 32'hA3,  1'b1, 14'h13, 32'hA3, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,         16'd0, 1'b0, 32'h0,   1'b0, 14'h0,  32'h0,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         16'd0, 1'b1, 32'hBAD, 1'b0, 14'h0,  32'h0,  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         16'd0, 1'b0, 32'h0,   1'b0, 14'h0,  32'h0,  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'h4000_0010, 16'd1, 1'b0, 32'h0,   1'b0, 14'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h4004_0010, 16'd0, 1'b0, 32'h0,   1'b0, 14'h0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,         16'd0, 1'b0, 32'h0,   1'b0, 14'h0,  32'h0,  1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].st, vecs[i].cfg, vecs[i].it, vecs[i].vld, vecs[i].dat, 1'b0);
            step();
            check($sformatf("vec%0d we", i),    64'(region_we), 64'(vecs[i].e_we));
            check($sformatf("vec%0d busy", i),  64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("vec%0d done", i),  64'(op_done), 64'(vecs[i].e_done));
            check($sformatf("vec%0d ovf", i),   64'(overflow), 64'(vecs[i].e_ovf));
            check($sformatf("vec%0d afull", i), 64'(in_almostfull), 64'(vecs[i].e_afull));
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d sel", i),   64'(region_wfifobram), 64'(2'b01));
                check($sformatf("vec%0d addr", i),  64'(region_waddr), 64'(vecs[i].e_addr));
                check($sformatf("vec%0d wdata", i), 64'(region_wdata), 64'(vecs[i].e_data));
            end
        end

        // BRAM wrap with keep: offset 0x3FFE, length 4, 2 iterations; a stray op_start mid-burst is ignored.
        exp_addr = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001, 14'h0002, 14'h0003, 14'h0004, 14'h0005};
        dones = 0;
        drive(1'b1, 32'h4004_BFFE, 16'd2, 1'b0, 32'h0, 1'b0);
        step();
        check("wrap busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive(i == 3, 32'h4001_0100, 16'd1, 1'b1, 32'h100 + 32'(i), 1'b0);
            step();
            if (op_done) dones++;
            check($sformatf("wrap%0d we", i),   64'(region_we), 64'd1);
            check($sformatf("wrap%0d addr", i), 64'(region_waddr), 64'(exp_addr[i]));
            check($sformatf("wrap%0d data", i), 64'(region_wdata), 64'(32'h100 + 32'(i)));
        end
        check("wrap done last", 64'(op_done), 64'd1);
        check("wrap busy end",  64'(busy), 64'd0);
        idle();
        step();
        check("wrap done count", 64'(dones), 64'd1);

        // FIFO mode, length 3 x 2; region almost-full raised with the first beat.
        writes = 0;
        dones  = 0;
        drive(1'b1, 32'h8003_0000, 16'd2, 1'b0, 32'h0, 1'b0);
        step();
        check("fifo afull start", 64'(in_almostfull), 64'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 32'h0, 16'd0, 1'b1, 32'h200 + 32'(i), (i == 0 || i == 1));
            step();
            if (region_we) writes++;
            if (op_done) dones++;
            check($sformatf("fifo%0d sel", i),  64'(region_wfifobram), 64'(2'b10));
            check($sformatf("fifo%0d data", i), 64'(region_wdata), 64'(32'h200 + 32'(i)));
            case (i)
                0, 1, 3, 4, 5: check($sformatf("fifo%0d afull", i), 64'(in_almostfull), 64'd1);
                default:       check($sformatf("fifo%0d afull", i), 64'(in_almostfull), 64'd0);
            endcase
        end
        idle();
        step();
        check("fifo writes", 64'(writes), 64'd6);
        check("fifo dones",  64'(dones), 64'd1);
        check("fifo busy",   64'(busy), 64'd0);

        // Reset mid-operation after 2 of 4 beats, then a clean rerun.
        drive(1'b1, 32'h4004_0010, 16'd1, 1'b0, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 16'd0, 1'b1, 32'h300 + 32'(i), 1'b0);
            step();
        end
        check("pre-rst we", 64'(region_we), 64'd1);
        idle();
        reset = 1'b0;
        #1;
        check("mid-rst we",    64'(region_we), 64'd0);
        check("mid-rst busy",  64'(busy), 64'd0);
        check("mid-rst afull", 64'(in_almostfull), 64'd1);
        check("mid-rst waddr", 64'(region_waddr), 64'd0);
        step();
        reset = 1'b1;
        drive(1'b1, 32'h4004_0010, 16'd1, 1'b0, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 16'd0, 1'b1, 32'h400 + 32'(i), 1'b0);
            step();
            check($sformatf("rerun%0d addr", i), 64'(region_waddr), 64'(14'h10 + 14'(i)));
            check($sformatf("rerun%0d done", i), 64'(op_done), 64'(i == 3));
        end
        idle();
        step();
        check("rerun busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/write_region.md
Name: write_region

Overview:
- Write-side counterpart of the region read engine.
- Consumes an internal data stream from a compute pipeline and writes it into a FIFO/BRAM region port, either at sequential BRAM addresses or by pushing into the region FIFO.
- Configured per operation by the same 32-bit configreg layout and 16-bit iteration count as the read side.
- Sits between a pipeline's result stream and the fifobram region.

Parameters:
- DATA_WIDTH, 512, width of one line.
- ADDR_WIDTH, 14, region BRAM address width; must be at least the offset field width.
- LOG2_ACCESS_SIZE, 14, width of the per-iteration line counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- op_start  in  1  one-cycle start pulse, sampled only in IDLE
- configreg  in  32  [31] write_fifo, [30] write_bram, [29:16] length, [15] keep_count_along_iterations, [13:0] offset
- iterations  in  16  repetitions of the length-line burst
- in_valid  in  1  input beat valid
- in_data  in  DATA_WIDTH  input beat
- in_almostfull  out  1  backpressure to producer; producer may still send up to 2 beats after assertion
- region_almostfull  in  1  region FIFO near full (FIFO mode only)
- region_we  out  1  region write enable
- region_wfifobram  out  2  01 = BRAM, 10 = FIFO
- region_waddr  out  ADDR_WIDTH  BRAM write address
- region_wdata  out  DATA_WIDTH  write data
- busy  out  1  operation in progress
- op_done  out  1  one-cycle pulse when the final line is written
- overflow  out  1  sticky flag: beat received while IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; region_we=0, wfifobram=00, waddr=0, wdata=0, busy=0, op_done=0, overflow=0, in_almostfull=1. Counters cleared.
- States: IDLE, BRAM_WRITE, FIFO_WRITE.
- IDLE + op_start:
  - Latch offset, length, iterations, keep flag.
  - Clear line and iteration counters.
  - If length==0 or iterations==0: stay IDLE and pulse op_done the next cycle.
  - Else if configreg[31]=1: go to FIFO_WRITE.
  - Else: go to BRAM_WRITE. configreg[31] takes priority when both [31] and [30] are set.
- Write path: each in_valid beat in a write state produces, on the next cycle:
  - region_we=1, wdata=in_data, wfifobram per mode.
  - BRAM mode: waddr=(offset+line_count) mod 2^ADDR_WIDTH.
  - Latency is exactly 1 cycle; no beat is ever dropped in a write state.
- End of burst: when line_count==length-1 and a beat is accepted, iteration_count increments.
  - Last iteration: return to IDLE; op_done pulses in the cycle region_we carries the final line.
  - Otherwise: line_count resets to 0. In BRAM mode with keep=1, offset += length (wraps mod 2^ADDR_WIDTH). With keep=0, the same addresses are overwritten.
- in_almostfull = 1 when any of these holds:
  - state is IDLE;
  - FIFO mode and region_almostfull;
  - remaining lines in the operation ≤ 2. This prevents overshoot past the last line.
- Beat on in_valid while IDLE (including the cycle op_start is seen): discarded, overflow set. overflow clears only on reset or the next accepted op_start.
- op_start outside IDLE: ignored.
- busy=1 in BRAM_WRITE/FIFO_WRITE.
- Reset asserted mid-operation: outputs return to reset values immediately; the partial burst is abandoned.

Decomposition:
- Shared package pipearch_common: t_writestate enum; access_properties struct (offset, length, iterations, write_bram, write_fifo, keep_count_along_iterations) reused from the read side; LOG2_ACCESS_SIZE constant; fifobram select encodings BRAM=2'b01, FIFO=2'b10.
- No sub-module required. The address/counter logic is small enough to remain in-line.

Test Plan:
- BRAM, offset=0x10, length=4, iterations=1, 4 back-to-back beats D0..D3 -> we on addresses 0x10..0x13 one cycle after each beat; op_done with D3; busy falls.
- BRAM, offset=0x3FFE, length=4, keep=1, iterations=2, 8 beats -> addresses 3FFE, 3FFF, 0000, 0001, then 0002..0005; single op_done at end.
- FIFO, length=3, iterations=2 -> 6 writes with wfifobram=10; raise region_almostfull mid-stream -> in_almostfull=1 next cycle; the producer's 2 in-flight beats are still written; no loss.
- length=0 -> no region writes; op_done 1 cycle after op_start; busy stays 0.
- in_valid while IDLE -> overflow=1, no write; next op_start clears overflow.
- Drop reset to 0 after 2 of 4 beats -> region_we=0 and busy=0 immediately; a new op_start after release runs cleanly from offset.
